// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master block: the bus-sequencing
// state enum and the width rule for the slave-select index port.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } spi_state_t;

  function automatic int ss_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timing for the SPI master: a half-period divider that ticks every
// clk_div+1 cycles while a transfer runs, plus a counter of ticks so far.
// The first 2*N ticks are SCK edges (odd = leading, even = trailing); the
// tick after the final edge marks the end of the trailing hold.
module spi_sck_gen #(
  parameter int DIV_W  = 8,
  parameter int EDGE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [EDGE_W-1:0] num_edges,
  output logic              tick,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic              last_edge
);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              in_edges;

  assign tick       = run && (div_cnt == clk_div);
  assign in_edges   = (edge_cnt < num_edges);
  assign lead_edge  = tick && in_edges && !edge_cnt[0];
  assign trail_edge = tick && in_edges && edge_cnt[0];
  assign last_edge  = trail_edge && (edge_cnt == num_edges - 1'b1);

  // Count cycles within a half-period and half-periods within a transfer; both clear while idle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      edge_cnt <= edge_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI bus master: run-time transfer length, all four CPOL/CPHA
// modes, programmable SCK divider and one-hot active-low slave selects.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds the lsb_first port,
// latched at start, selecting LSB-first shifting and assembly.
module spi_master
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_SS = 1,
  parameter  int DIV_W  = 8,
  localparam int LEN_W  = $clog2(DATA_W),
  localparam int SS_W   = ss_width(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi,
  input  logic              miso
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic              lsb_first
`endif
);

  localparam int EDGE_W = LEN_W + 2;

  spi_state_t        state;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              lsb_in;
  logic [DIV_W-1:0]  div_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_sr;
  logic [LEN_W-1:0]  tx_idx;
  logic [LEN_W-1:0]  rx_idx;
  logic [LEN_W-1:0]  tx_idx_nxt;
  logic [LEN_W-1:0]  rx_idx_nxt;
  logic [LEN_W-1:0]  first_idx;
  logic [EDGE_W-2:0] num_bits;
  logic [EDGE_W-1:0] num_edges;
  logic              run;
  logic              tick;
  logic              lead_edge;
  logic              trail_edge;
  logic              last_edge;
  logic              start_ok;
  logic              sample_now;
  logic              shift_now;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;

  // Bit order is captured with the other transfer settings so it cannot change mid-transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_q <= 1'b0;
    end else if (start_ok) begin
      lsb_q <= lsb_first;
    end
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  assign first_idx  = lsb_in ? '0 : xfer_len;
  assign tx_idx_nxt = lsb_q ? tx_idx + 1'b1 : tx_idx - 1'b1;
  assign rx_idx_nxt = lsb_q ? rx_idx + 1'b1 : rx_idx - 1'b1;
  assign num_bits   = (EDGE_W-1)'(len_q) + 1'b1;
  assign num_edges  = {num_bits, 1'b0};
  assign run        = state inside {LEAD, SHIFT, TRAIL};
  assign start_ok   = (state == IDLE) && start && !busy &&
                      ({1'b0, ss_sel} < (SS_W+1)'(NUM_SS));
  assign sample_now = cpha_q ? trail_edge : lead_edge;
  assign shift_now  = cpha_q ? (lead_edge && (state == SHIFT))
                             : (trail_edge && !last_edge);

  spi_sck_gen #(
    .DIV_W  (DIV_W),
    .EDGE_W (EDGE_W)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clk_div    (div_q),
    .num_edges  (num_edges),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge)
  );

  // Bus sequencing, shift datapath and registered pin outputs in one state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sck     <= 1'b0;
      ss_n    <= '1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rx_sr   <= '0;
      tx_idx  <= '0;
      rx_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (sample_now) begin
        rx_sr[rx_idx] <= miso;
        rx_idx        <= rx_idx_nxt;
      end
      if (shift_now) begin
        mosi   <= tx_q[tx_idx_nxt];
        tx_idx <= tx_idx_nxt;
      end
      if (lead_edge || trail_edge) begin
        sck <= ~sck;
      end
      case (state)
        IDLE: begin
          sck  <= cpol;
          busy <= 1'b0;
          if (start_ok) begin
            state  <= LEAD;
            busy   <= 1'b1;
            cpol_q <= cpol;
            cpha_q <= cpha;
            div_q  <= clk_div;
            len_q  <= xfer_len;
            tx_q   <= tx_data;
            rx_sr  <= '0;
            tx_idx <= first_idx;
            rx_idx <= first_idx;
            mosi   <= tx_data[first_idx];
            ss_n   <= ~(NUM_SS'(1) << ss_sel);
          end
        end
        LEAD: begin
          if (lead_edge) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_edge) begin
            state <= TRAIL;
          end
        end
        TRAIL: begin
          if (tick) begin
            state <= DONE;
          end
        end
        DONE: begin
          ss_n    <= '1;
          rx_data <= rx_sr;
          done    <= 1'b1;
          mosi    <= 1'b0;
          sck     <= cpol_q;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI bus master: the next generation of our fixed-function SPI controller. It supports run-time length transfers up to DATA_W bits, all four CPOL/CPHA modes, a programmable SCK divider and NUM_SS one-hot slave selects. The block sits between the CPU register interface and the SPI pins, and owns both the shift datapath and the bus sequencing.

## Interface
- DATA_W, 8: maximum bits per transfer (≥2).
- NUM_SS, 1: number of slave-select lines.
- DIV_W, 8: width of clock-divider field.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- cpol  in  1  SCK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles.
- xfer_len  in  $clog2(DATA_W)  bits to transfer minus 1.
- ss_sel  in  max(1,$clog2(NUM_SS))  target slave index.
- tx_data  in  DATA_W  word to send, right-justified.
- rx_data  out  DATA_W  received word, right-justified; stable until next done.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- sck  out  1  SPI clock.
- ss_n  out  NUM_SS  active-low slave selects.
- mosi  out  1  serial out.
- miso  in  1  serial in; sampled directly, no synchroniser.

## Operation
- States: IDLE, LEAD, SHIFT, TRAIL, DONE.
- IDLE: sck = cpol input (registered each cycle); ss_n all 1. On start with ss_sel < NUM_SS: latch cpol, cpha, clk_div, xfer_len, ss_sel; load tx_data into shift reg; go to LEAD. A start with ss_sel ≥ NUM_SS is ignored (no busy, no done).
- LEAD: selected ss_n low; first bit on mosi; wait one half-period; go to SHIFT.
- SHIFT: 2·(xfer_len+1) SCK edges, one per half-period. Odd edges are leading, even edges trailing.
  - cpha=0: sample miso on leading edges, shift mosi on trailing edges.
  - cpha=1: shift mosi on leading edges (except edge 1, where the first bit already holds), sample on trailing edges.
- After the last edge: TRAIL. Hold ss_n low and sck = cpol for one half-period, then go to DONE.
- DONE: ss_n high; rx_data updated; done=1 for one cycle; go to IDLE.
- Bit order: MSB-first from bit xfer_len. Unused upper rx_data bits are 0.
- start while busy: ignored. Input changes during a transfer have no effect.
- rst mid-transfer: return immediately to IDLE, no done pulse.

## Timing
- Reset values: sck=0, ss_n=all 1, mosi=0, busy=0, done=0, rx_data=0.
- Let H = clk_div+1 and N = xfer_len+1.
- start accepted at cycle 0: ss_n falls at cycle 1; first sck edge at cycle 1+H.
- Edge k (k=1…2N) occurs at cycle 1+k·H.
- done asserts at cycle 1+(2N+1)·H+1.
- busy is high on cycles 1 through the done cycle inclusive.
- A new start is accepted the cycle after done.
- clk_div=0 gives the maximum SCK rate, clk/2.
- Divider counter width is DIV_W; edge counter is $clog2(2·DATA_W)+1 bits. No wrap-around occurs at the maximum setting.

## Configuration
- SPI_MASTER_LSB_FIRST_EN defined: adds input port lsb_first (1 bit). It is latched at start; when high, bits shift out from bit 0 upward and received bits assemble into rx_data[0..xfer_len] in arrival order.
- Undefined: the port is absent and transfers are MSB-first only.

## Structure
- spi_pkg holds the state enum (IDLE, LEAD, SHIFT, TRAIL, DONE) and the helper function for the ss_sel width.
- One sub-module, spi_sck_gen, contains the half-period divider and the edge counter. It outputs single-cycle lead_edge and trail_edge strobes plus a last_edge flag.
- Shift register, sampling and FSM live in spi_master.

## Test plan
- Mode 0, DATA_W=8, clk_div=1, xfer_len=7, tx=0xA5, miso loopback from mosi -> rx_data=0xA5; done at cycle 1+17·2+1=36; 8 rising sck edges.
- Modes 1/2/3 with tx=0x3C and slave model returning 0xC3 -> rx_data=0xC3 in each mode; sck idle level equals cpol before ss_n falls and after it rises.
- NUM_SS=4, ss_sel=2 -> only ss_n[2] goes low; then ss_sel=5 with start -> busy and done never assert.
- xfer_len=3, tx=0xF9, slave returns 0b1010 -> 4 bits on mosi = 1001; rx_data=0x0A.
- start pulsed again mid-transfer, and rst asserted mid-SHIFT -> second start ignored; after rst, all outputs at reset values on the next cycle and no done pulse.
- With SPI_MASTER_LSB_FIRST_EN, lsb_first=1, tx=0x01 -> first mosi bit is 1; loopback rx_data=0x01.
